// File: rtl/text_line_render.sv
// Scanline text renderer: fetches char/attr words and glyph rows, maps them through
// a fixed 16-colour palette and writes one line of RGB444 pixels behind the reader.
//
// state      | meaning
// IDLE       | waiting for an accepted line_go
// FETCH_CHAR | text word read strobe active
// FETCH_FONT | glyph row read strobe active
// LOAD       | glyph row captured; first pixel may be issued
// EMIT       | remaining pixels of the character, gated by the reader position
module text_line_render #(
  parameter int H_VISIBLE = 800,
  parameter int V_VISIBLE = 600,
  parameter int COLS      = 100,
  parameter int LAG       = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        line_go,
  input  logic [9:0]  render_line,
  input  logic [10:0] rd_pos,
  output logic        tm_rd,
  output logic [12:0] tm_addr,
  input  logic [15:0] tm_data,
  output logic        font_rd,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        pixbuf_wr,
  output logic [9:0]  pixbuf_wr_addr,
  output logic [15:0] pixbuf_wr_data,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, FETCH_CHAR, FETCH_FONT, LOAD, EMIT} state_t;

  localparam logic [9:0]  V_LIM    = 10'(V_VISIBLE);
  localparam logic [10:0] X_LIM    = 11'(H_VISIBLE);
  localparam logic [10:0] LAG_W    = 11'(LAG);
  localparam logic [6:0]  COL_LAST = 7'(COLS - 1);

  function automatic logic [12:0] row_base(input logic [5:0] r);
    logic [12:0] rw;
    rw = {7'd0, r};
    return (rw << 6) + (rw << 5) + (rw << 2);
  endfunction

  function automatic logic [11:0] palette(input logic [3:0] idx);
    logic [11:0] c;
    case (idx)
      4'h0: c = 12'h000;  4'h1: c = 12'h00A;  4'h2: c = 12'h0A0;  4'h3: c = 12'h0AA;
      4'h4: c = 12'hA00;  4'h5: c = 12'hA0A;  4'h6: c = 12'hA50;  4'h7: c = 12'hAAA;
      4'h8: c = 12'h555;  4'h9: c = 12'h55F;  4'hA: c = 12'h5F5;  4'hB: c = 12'h5FF;
      4'hC: c = 12'hF55;  4'hD: c = 12'hF5F;  4'hE: c = 12'hFF5;  default: c = 12'hFFF;
    endcase
    return c;
  endfunction

  state_t      state, state_nx;
  logic [6:0]  col, col_nx;
  logic [9:0]  x, x_nx;
  logic [3:0]  g, g_nx;
  logic [12:0] base, base_nx;
  logic [3:0]  fg, fg_nx, bg, bg_nx;
  logic [7:0]  shreg, shreg_nx;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic        done_pend, done_pend_nx;

  logic        tm_rd_nx, font_rd_nx, wr_nx, busy_nx, done_nx, overrun_nx;
  logic [12:0] tm_addr_nx;
  logic [11:0] font_addr_nx;
  logic [9:0]  wr_addr_nx;
  logic [15:0] wr_data_nx;

  logic        go_ok, gate;
  logic [7:0]  src;
  logic [2:0]  cnt;
  logic [3:0]  pix_idx;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    col_nx       = col;
    x_nx         = x;
    g_nx         = g;
    base_nx      = base;
    fg_nx        = fg;
    bg_nx        = bg;
    shreg_nx     = shreg;
    bit_cnt_nx   = bit_cnt;
    done_pend_nx = 1'b0;
    tm_rd_nx     = 1'b1;
    font_rd_nx   = 1'b1;
    wr_nx        = 1'b1;
    tm_addr_nx   = tm_addr;
    font_addr_nx = font_addr;
    wr_addr_nx   = pixbuf_wr_addr;
    wr_data_nx   = pixbuf_wr_data;
    busy_nx      = busy;
    done_nx      = done_pend;
    overrun_nx   = overrun;

    go_ok   = line_go && (render_line < V_LIM);
    gate    = (({1'b0, x} + LAG_W) <= rd_pos) && ({1'b0, x} < X_LIM);
    src     = (state == LOAD) ? font_data : shreg;
    cnt     = (state == LOAD) ? 3'd0 : bit_cnt;
    pix_idx = src[7] ? fg : bg;

    if (done_pend) busy_nx = 1'b0;

    case (state)
      IDLE: state_nx = IDLE;
      FETCH_CHAR: begin
        fg_nx        = tm_data[11:8];
        bg_nx        = tm_data[15:12];
        font_rd_nx   = 1'b0;
        font_addr_nx = {tm_data[7:0], g};
        state_nx     = FETCH_FONT;
      end
      FETCH_FONT: state_nx = LOAD;
      // The first pixel is issued straight from font_data so a character costs 10 cycles.
      LOAD, EMIT: begin
        if (gate) begin
          wr_nx      = 1'b0;
          wr_addr_nx = x;
          wr_data_nx = {4'h0, palette(pix_idx)};
          shreg_nx   = {src[6:0], 1'b0};
          bit_cnt_nx = cnt + 3'd1;
          x_nx       = x + 10'd1;
          state_nx   = EMIT;
          if (cnt == 3'd7) begin
            if (col == COL_LAST) begin
              state_nx     = IDLE;
              done_pend_nx = 1'b1;
            end else begin
              col_nx     = col + 7'd1;
              tm_rd_nx   = 1'b0;
              tm_addr_nx = base + {6'd0, col_nx};
              state_nx   = FETCH_CHAR;
            end
          end
        end else begin
          shreg_nx   = src;
          bit_cnt_nx = cnt;
          state_nx   = EMIT;
        end
      end
      default: state_nx = IDLE;
    endcase

    // A valid line_go always wins: abort whatever is in flight and restart at column 0.
    if (go_ok) begin
      overrun_nx   = overrun | busy;
      state_nx     = FETCH_CHAR;
      g_nx         = render_line[3:0];
      base_nx      = row_base(render_line[9:4]);
      tm_addr_nx   = row_base(render_line[9:4]);
      tm_rd_nx     = 1'b0;
      font_rd_nx   = 1'b1;
      wr_nx        = 1'b1;
      col_nx       = 7'd0;
      x_nx         = 10'd0;
      busy_nx      = 1'b1;
      done_pend_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      col            <= '0;
      x              <= '0;
      g              <= '0;
      base           <= '0;
      fg             <= '0;
      bg             <= '0;
      shreg          <= '0;
      bit_cnt        <= '0;
      done_pend      <= 1'b0;
      tm_rd          <= 1'b1;
      tm_addr        <= '0;
      font_rd        <= 1'b1;
      font_addr      <= '0;
      pixbuf_wr      <= 1'b1;
      pixbuf_wr_addr <= '0;
      pixbuf_wr_data <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      col            <= col_nx;
      x              <= x_nx;
      g              <= g_nx;
      base           <= base_nx;
      fg             <= fg_nx;
      bg             <= bg_nx;
      shreg          <= shreg_nx;
      bit_cnt        <= bit_cnt_nx;
      done_pend      <= done_pend_nx;
      tm_rd          <= tm_rd_nx;
      tm_addr        <= tm_addr_nx;
      font_rd        <= font_rd_nx;
      font_addr      <= font_addr_nx;
      pixbuf_wr      <= wr_nx;
      pixbuf_wr_addr <= wr_addr_nx;
      pixbuf_wr_data <= wr_data_nx;
      busy           <= busy_nx;
      done           <= done_nx;
      overrun        <= overrun_nx;
    end
  end

endmodule

// File: tb/tb_text_line_render.sv
// Bench for text_line_render: memories are modelled as arrays, each rendered line is
// compared against a pixel image computed directly from the text/font/palette rules.
`timescale 1ns/100ps
module tb_text_line_render;

  logic        clk = 1'b0, nrst = 1'b1, line_go = 1'b0;
  logic [9:0]  render_line = '0;
  logic [10:0] rd_pos = '0;
  logic        tm_rd, font_rd, pixbuf_wr, busy, done, overrun;
  logic [12:0] tm_addr;
  logic [15:0] tm_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [9:0]  pixbuf_wr_addr;
  logic [15:0] pixbuf_wr_data;

  logic [15:0] tmem [0:8191];
  logic [7:0]  fmem [0:4095];
  assign tm_data   = tmem[tm_addr];
  assign font_data = fmem[font_addr];

  text_line_render dut (
    .clk(clk), .nrst(nrst), .line_go(line_go), .render_line(render_line), .rd_pos(rd_pos),
    .tm_rd(tm_rd), .tm_addr(tm_addr), .tm_data(tm_data),
    .font_rd(font_rd), .font_addr(font_addr), .font_data(font_data),
    .pixbuf_wr(pixbuf_wr), .pixbuf_wr_addr(pixbuf_wr_addr), .pixbuf_wr_data(pixbuf_wr_data),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #12.5 clk = ~clk;

  int vec_cnt = 0, err_cnt = 0;
  bit rd_run = 1'b0;
  logic [15:0] cap [0:799];
  logic [11:0] exp_pix [0:799];
  int          wr_q[$];
  logic [15:0] wd_q[$];
  int          tm_q[$];
  int          fa_q[$];
  int          done_cnt = 0, gate_viol = 0, oob = 0;
  logic [10:0] rd_dec = '0;

  // rd_pos as seen by the DUT at the edge that decided the write now visible
  always @(posedge clk) rd_dec <= rd_pos;

  always @(negedge clk) begin
    if (pixbuf_wr === 1'b0) begin
      wr_q.push_back(int'(pixbuf_wr_addr));
      wd_q.push_back(pixbuf_wr_data);
      if (pixbuf_wr_addr < 10'd800) cap[pixbuf_wr_addr] = pixbuf_wr_data;
      else oob++;
      if (int'(pixbuf_wr_addr) + 4 > int'(rd_dec)) gate_viol++;
    end
    if (tm_rd === 1'b0)   tm_q.push_back(int'(tm_addr));
    if (font_rd === 1'b0) fa_q.push_back(int'(font_addr));
    if (done === 1'b1)    done_cnt++;
  end

  function automatic logic [11:0] pal(input logic [3:0] i);
    logic [11:0] t [16];
    t = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
          12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
    return t[i];
  endfunction

  function automatic void build_exp(input logic [9:0] ln);
    int base;
    logic [15:0] w;
    logic [7:0] gl;
    base = int'(ln[9:4]) * 100;
    for (int c = 0; c < 100; c++) begin
      w  = tmem[base + c];
      gl = fmem[int'(w[7:0]) * 16 + int'(ln[3:0])];
      for (int b = 0; b < 8; b++) exp_pix[c*8 + b] = pal(gl[7-b] ? w[11:8] : w[15:12]);
    end
  endfunction

  function automatic int pix_bad();
    int n = 0;
    for (int i = 0; i < 800; i++) if (cap[i] !== {4'h0, exp_pix[i]}) n++;
    return n;
  endfunction

  task automatic clear_mon();
    wr_q.delete(); wd_q.delete(); tm_q.delete(); fa_q.delete();
    for (int i = 0; i < 800; i++) cap[i] = 'x;
    done_cnt = 0; gate_viol = 0; oob = 0;
  endtask

  task automatic rand_mem();
    for (int a = 0; a < 8192; a++) tmem[a] = 16'($urandom);
    for (int a = 0; a < 4096; a++) fmem[a] = 8'($urandom);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (rd_run) rd_pos = (rd_pos == 11'd1055) ? 11'd0 : rd_pos + 11'd1;
  endtask

  task automatic pulse_go(input logic [9:0] ln);
    render_line = ln; line_go = 1'b1;
    if (rd_run) rd_pos = '0;
    tick();
    line_go = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < 3000) begin tick(); cyc++; end
  endtask

  task automatic test_reset();
    nrst = 1'b1; #2; nrst = 1'b0; #2;
    vec_cnt++; if (tm_rd !== 1'b1) begin err_cnt++; $display("FAIL reset_tm_rd got %b want 1", tm_rd); end
    vec_cnt++; if (font_rd !== 1'b1) begin err_cnt++; $display("FAIL reset_font_rd got %b want 1", font_rd); end
    vec_cnt++; if (pixbuf_wr !== 1'b1) begin err_cnt++; $display("FAIL reset_pixbuf_wr got %b want 1", pixbuf_wr); end
    vec_cnt++;
    if ({tm_addr, font_addr, pixbuf_wr_addr, pixbuf_wr_data} !== 51'd0) begin
      err_cnt++; $display("FAIL reset_addr_data got %h %h %h %h want 0", tm_addr, font_addr, pixbuf_wr_addr, pixbuf_wr_data);
    end
    vec_cnt++;
    if ({busy, done, overrun} !== 3'b000) begin
      err_cnt++; $display("FAIL reset_flags got %b%b%b want 000", busy, done, overrun);
    end
    @(posedge clk); #1; nrst = 1'b1; tick();
  endtask

  task automatic test_plan_line();
    int cyc, bad;
    for (int a = 0; a < 100; a++) tmem[a] = 16'h1F41;
    for (int a = 0; a < 4096; a++) fmem[a] = 8'h80;
    rd_run = 1'b0; rd_pos = 11'd1000;
    clear_mon();
    pulse_go(10'd0);
    vec_cnt++; if (tm_rd !== 1'b0 || tm_addr !== 13'd0 || busy !== 1'b1) begin
      err_cnt++; $display("FAIL plan_cycle1 got tm_rd=%b addr=%0d busy=%b want 0/0/1", tm_rd, tm_addr, busy); end
    tick();
    vec_cnt++; if (font_rd !== 1'b0 || font_addr !== 12'h410) begin
      err_cnt++; $display("FAIL plan_cycle2 got font_rd=%b addr=%h want 0/410", font_rd, font_addr); end
    tick();
    vec_cnt++; if (pixbuf_wr !== 1'b1) begin err_cnt++; $display("FAIL plan_cycle3 got wr=%b want 1", pixbuf_wr); end
    tick();
    vec_cnt++; if (pixbuf_wr !== 1'b0 || pixbuf_wr_addr !== 10'd0 || pixbuf_wr_data !== 16'h0FFF) begin
      err_cnt++; $display("FAIL plan_cycle4 got wr=%b x=%0d d=%h want 0/0/0FFF", pixbuf_wr, pixbuf_wr_addr, pixbuf_wr_data); end
    tick();
    vec_cnt++; if (pixbuf_wr !== 1'b0 || pixbuf_wr_addr !== 10'd1 || pixbuf_wr_data !== 16'h000A) begin
      err_cnt++; $display("FAIL plan_cycle5 got wr=%b x=%0d d=%h want 0/1/000A", pixbuf_wr, pixbuf_wr_addr, pixbuf_wr_data); end
    wait_done(5, cyc);
    vec_cnt++; if (cyc != 1002) begin err_cnt++; $display("FAIL plan_done_cycle got %0d want 1002", cyc); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL plan_busy_end got %b want 0", busy); end
    tick(); tick();
    build_exp(10'd0);
    bad = pix_bad();
    vec_cnt++; if (bad != 0 || wr_q.size() != 800) begin
      err_cnt++; $display("FAIL plan_pixels got %0d bad, %0d writes want 0, 800", bad, wr_q.size()); end
    bad = 0;
    foreach (tm_q[i]) if (tm_q[i] != i) bad++;
    vec_cnt++; if (bad != 0 || tm_q.size() != 100) begin
      err_cnt++; $display("FAIL plan_tm_addr got %0d bad of %0d want 0 of 100", bad, tm_q.size()); end
    vec_cnt++; if (done_cnt != 1) begin err_cnt++; $display("FAIL plan_done_pulses got %0d want 1", done_cnt); end
  endtask

  task automatic test_glyph();
    int cyc, bad;
    logic [15:0] gx [8];
    gx = '{16'h00A0, 16'h0000, 16'h00A0, 16'h0000, 16'h0000, 16'h00A0, 16'h0000, 16'h00A0};
    for (int a = 0; a < 100; a++) tmem[a] = 16'h02A5;
    fmem[12'hA55] = 8'hA5;
    rd_run = 1'b1;
    clear_mon();
    pulse_go(10'd5);
    wait_done(1, cyc);
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      vec_cnt++; if (cap[i] !== gx[i]) begin err_cnt++; $display("FAIL glyph_px%0d got %h want %h", i, cap[i], gx[i]); end
    end
    build_exp(10'd5);
    bad = pix_bad();
    vec_cnt++; if (bad != 0 || cyc >= 3000) begin err_cnt++; $display("FAIL glyph_line got %0d bad cyc=%0d want 0", bad, cyc); end
  endtask

  task automatic test_random_lines();
    logic [9:0] lines [3];
    int cyc, bad, base;
    lines = '{10'd599, 10'($urandom_range(0, 598)), 10'($urandom_range(0, 598))};
    rd_run = 1'b1;
    foreach (lines[n]) begin
      rand_mem();
      clear_mon();
      pulse_go(lines[n]);
      wait_done(1, cyc);
      tick(); tick();
      vec_cnt++; if (cyc >= 3000) begin err_cnt++; $display("FAIL rand_timeout line=%0d cyc=%0d want <3000", lines[n], cyc); end
      build_exp(lines[n]);
      bad = pix_bad();
      vec_cnt++; if (bad != 0 || wr_q.size() != 800 || oob != 0) begin
        err_cnt++; $display("FAIL rand_pixels line=%0d got %0d bad %0d writes %0d oob want 0/800/0", lines[n], bad, wr_q.size(), oob); end
      base = (int'(lines[n]) / 16) * 100;
      bad = 0;
      foreach (tm_q[i]) if (tm_q[i] != base + i) bad++;
      vec_cnt++; if (bad != 0 || tm_q.size() != 100) begin
        err_cnt++; $display("FAIL rand_tm_addr line=%0d got first %0d, %0d bad want first %0d", lines[n], tm_q[0], bad, base); end
      bad = 0;
      foreach (fa_q[i]) if (fa_q[i] != int'(tmem[base + i][7:0]) * 16 + int'(lines[n]) % 16) bad++;
      vec_cnt++; if (bad != 0 || fa_q.size() != 100) begin
        err_cnt++; $display("FAIL rand_font_addr line=%0d got %0d bad of %0d want 0 of 100", lines[n], bad, fa_q.size()); end
      vec_cnt++; if (gate_viol != 0) begin err_cnt++; $display("FAIL rand_gate line=%0d got %0d violations want 0", lines[n], gate_viol); end
    end
  endtask

  task automatic test_ignored();
    int cyc, bad;
    rd_run = 1'b0; rd_pos = 11'd1000;
    clear_mon();
    pulse_go(10'd600);
    for (int i = 0; i < 10; i++) tick();
    pulse_go(10'd1023);
    for (int i = 0; i < 10; i++) tick();
    vec_cnt++; if (tm_q.size() != 0 || wr_q.size() != 0 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL ignored_idle got %0d reads %0d writes busy=%b want 0/0/0", tm_q.size(), wr_q.size(), busy); end
    rand_mem();
    clear_mon();
    pulse_go(10'd77);
    for (int i = 0; i < 200; i++) tick();
    pulse_go(10'd700);
    wait_done(202, cyc);
    tick(); tick();
    build_exp(10'd77);
    bad = pix_bad();
    vec_cnt++; if (bad != 0 || wr_q.size() != 800 || cyc >= 3000) begin
      err_cnt++; $display("FAIL ignored_busy_line got %0d bad %0d writes want 0/800", bad, wr_q.size()); end
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL ignored_overrun got %b want 0", overrun); end
  endtask

  task automatic test_stall();
    int cyc, bad;
    rand_mem();
    rd_run = 1'b0; rd_pos = 11'd3;
    clear_mon();
    pulse_go(10'd300);
    for (int i = 0; i < 20; i++) tick();
    vec_cnt++; if (wr_q.size() != 0 || pixbuf_wr !== 1'b1) begin
      err_cnt++; $display("FAIL stall_hold got %0d writes wr=%b want 0/1", wr_q.size(), pixbuf_wr); end
    rd_pos = 11'd4;
    vec_cnt++; if (pixbuf_wr !== 1'b1) begin err_cnt++; $display("FAIL stall_early got wr=%b want 1", pixbuf_wr); end
    tick();
    vec_cnt++; if (pixbuf_wr !== 1'b0 || pixbuf_wr_addr !== 10'd0) begin
      err_cnt++; $display("FAIL stall_release got wr=%b x=%0d want 0/0", pixbuf_wr, pixbuf_wr_addr); end
    rd_run = 1'b1;
    wait_done(23, cyc);
    tick(); tick();
    build_exp(10'd300);
    bad = pix_bad();
    vec_cnt++; if (bad != 0 || wr_q.size() != 800 || gate_viol != 0 || cyc >= 3000) begin
      err_cnt++; $display("FAIL stall_line got %0d bad %0d writes %0d gate want 0/800/0", bad, wr_q.size(), gate_viol); end
  endtask

  task automatic test_overrun();
    logic [11:0] exp_a [0:799];
    logic [9:0] la, lb;
    int cyc, k, bad;
    rand_mem();
    la = 10'($urandom_range(0, 299));
    lb = 10'($urandom_range(300, 599));
    build_exp(la);
    for (int i = 0; i < 800; i++) exp_a[i] = exp_pix[i];
    build_exp(lb);
    rd_run = 1'b1;
    clear_mon();
    pulse_go(la);
    for (int i = 0; i < 499; i++) tick();
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL ovr_before got %b want 0", overrun); end
    pulse_go(lb);
    vec_cnt++; if (overrun !== 1'b1 || busy !== 1'b1 || tm_rd !== 1'b0 || int'(tm_addr) != (int'(lb) / 16) * 100) begin
      err_cnt++; $display("FAIL ovr_restart got ovr=%b busy=%b tm_rd=%b addr=%0d want 1/1/0/%0d", overrun, busy, tm_rd, tm_addr, (int'(lb) / 16) * 100); end
    wait_done(1, cyc);
    tick(); tick();
    k = 0;
    for (int i = 1; i < wr_q.size(); i++) if (k == 0 && wr_q[i] == 0) k = i;
    bad = 0;
    for (int i = 0; i < k; i++) if (wr_q[i] != i || wd_q[i] !== {4'h0, exp_a[i]}) bad++;
    for (int i = k; i < wr_q.size(); i++) if (wr_q[i] != i - k || wd_q[i] !== {4'h0, exp_pix[i - k]}) bad++;
    vec_cnt++; if (k < 300 || k > 500 || bad != 0 || wr_q.size() - k != 800) begin
      err_cnt++; $display("FAIL ovr_writes got abort=%0d bad=%0d new=%0d want abort 300..500, 0 bad, 800 new", k, bad, wr_q.size() - k); end
    vec_cnt++; if (done_cnt != 1 || overrun !== 1'b1 || cyc >= 3000) begin
      err_cnt++; $display("FAIL ovr_done got %0d pulses ovr=%b want 1/1", done_cnt, overrun); end
  endtask

  task automatic test_reset_mid();
    int cyc, bad, n;
    rand_mem();
    rd_run = 1'b1;
    clear_mon();
    pulse_go(10'd450);
    for (int i = 0; i < 300; i++) tick();
    #5; nrst = 1'b0; #1;
    vec_cnt++; if (pixbuf_wr !== 1'b1 || busy !== 1'b0 || tm_rd !== 1'b1 || font_rd !== 1'b1) begin
      err_cnt++; $display("FAIL rstmid_async got wr=%b busy=%b tm_rd=%b font_rd=%b want 1/0/1/1", pixbuf_wr, busy, tm_rd, font_rd); end
    n = wr_q.size();
    for (int i = 0; i < 5; i++) tick();
    vec_cnt++; if (wr_q.size() != n) begin err_cnt++; $display("FAIL rstmid_writes got %0d want %0d", wr_q.size(), n); end
    nrst = 1'b1;
    tick();
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL rstmid_overrun got %b want 0", overrun); end
    rand_mem();
    clear_mon();
    pulse_go(10'd123);
    wait_done(1, cyc);
    tick(); tick();
    build_exp(10'd123);
    bad = pix_bad();
    vec_cnt++; if (bad != 0 || wr_q.size() != 800 || done_cnt != 1 || cyc >= 3000) begin
      err_cnt++; $display("FAIL rstmid_line got %0d bad %0d writes %0d done want 0/800/1", bad, wr_q.size(), done_cnt); end
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) tmem[a] = '0;
    for (int a = 0; a < 4096; a++) fmem[a] = '0;
    test_reset();
    test_plan_line();
    test_glyph();
    test_random_lines();
    test_ignored();
    test_stall();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
